// File: rtl/dmem_dp_pkg.sv
// Shared defaults and state encoding for the dual-port data memory.
// The defaults mirror DATA_W, DMEM_DEPTH and DMEM_ADDR_W from def.h.
package dmem_dp_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 1024;
    localparam int DMEM_ADDR_W = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_clr_seq.sv
// Post-reset clear sequencer: walks every word once with a zero write, then
// reports ready one registered cycle after the last clear write.
module dmem_clr_seq
    import dmem_dp_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int DEPTH      = 1024,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clr_we,
    output logic [CNT_W-1:0] clr_addr,
    output logic             ready
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    dmem_state_e      state, state_nxt;
    logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT_CLEAR ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            ready   <= (state == ST_READY);
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == LAST) begin
                    state_nxt   = ST_READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + CNT_W'(1);
                end
            end
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
    end

    assign clr_addr = clr_cnt;

endmodule

// File: rtl/dmem_dp.sv
// Dual-port data memory: port A is the byte-enabled CPU load/store port,
// port B a read-only sidecar port that sees same-edge port A writes.
module dmem_dp
    import dmem_dp_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wd,
    output logic [DATA_W-1:0]   a_rd,
    output logic                a_rvalid,
    output logic                a_err,
    input  logic                b_req,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_rd,
    output logic                b_rvalid,
    output logic                b_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic             clr_we;
    logic [IDX_W-1:0] clr_addr;
    logic             a_acc, b_acc, a_inr, b_inr, a_wr;
    logic [IDX_W-1:0] a_idx, b_idx;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [NB-1:0]    wr_be;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] b_word;

    dmem_clr_seq #(
        .CNT_W      (IDX_W),
        .DEPTH      (DEPTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    assign a_acc = a_req & ready;
    assign b_acc = b_req & ready;
    assign a_inr = ({1'b0, a_addr} < DEPTH_L);
    assign b_inr = ({1'b0, b_addr} < DEPTH_L);
    assign a_idx = a_addr[IDX_W-1:0];
    assign b_idx = b_addr[IDX_W-1:0];
    assign a_wr  = a_acc & a_we & a_inr;

    // Clear writes only happen while ready=0, so they never contend with port A.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = a_idx;
        wr_be   = a_be;
        wr_data = a_wd;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_idx  = clr_addr;
            wr_be   = '1;
            wr_data = '0;
        end else if (a_wr) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Port B returns the post-write word when port A writes the same address.
    always_comb begin
        b_word = mem[b_idx];
        for (int i = 0; i < NB; i++) begin
            if (a_wr && (a_addr == b_addr) && a_be[i]) b_word[8*i +: 8] = a_wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rd     <= '0;
            a_rvalid <= 1'b0;
            a_err    <= 1'b0;
            b_rd     <= '0;
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;
        end else begin
            a_rvalid <= a_acc & ~a_we;
            a_err    <= a_acc & ~a_inr;
            b_rvalid <= b_acc;
            b_err    <= b_acc & ~b_inr;
            if (a_acc && !a_we) a_rd <= a_inr ? mem[a_idx] : '0;
            if (b_acc) b_rd <= b_inr ? b_word : '0;
        end
    end

endmodule

// File: tb/tb_dmem_dp.sv
// Directed bench for dmem_dp (DEPTH=8): clear/ready timing, byte enables,
// same-edge forwarding, range errors, request gating and restart.
module tb_dmem_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req;
    logic [3:0]  a_be;
    logic [15:0] a_addr, b_addr;
    logic [31:0] a_wd;
    logic        ready, a_rvalid, a_err, b_rvalid, b_err;
    logic [31:0] a_rd, b_rd;
    logic        ready0, a_rvalid0, a_err0, b_rvalid0, b_err0;
    logic [31:0] a_rd0, b_rd0;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [8];

    always #5 clk = ~clk;

    dmem_dp #(.DATA_W(32), .ADDR_W(16), .DEPTH(8), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wd(a_wd),
        .a_rd(a_rd), .a_rvalid(a_rvalid), .a_err(a_err),
        .b_req(b_req), .b_addr(b_addr), .b_rd(b_rd), .b_rvalid(b_rvalid), .b_err(b_err)
    );

    dmem_dp #(.DATA_W(32), .ADDR_W(16), .DEPTH(8), .INIT_CLEAR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wd(a_wd),
        .a_rd(a_rd0), .a_rvalid(a_rvalid0), .a_err(a_err0),
        .b_req(b_req), .b_addr(b_addr), .b_rd(b_rd0), .b_rvalid(b_rvalid0), .b_err(b_err0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_req = 1'b0;
        a_we  = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
        a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wd = data; a_be = be;
        tick;
        idle;
    endtask

    task automatic do_read_a(input logic [15:0] addr);
        a_req = 1'b1; a_we = 1'b0; a_addr = addr;
        tick;
        idle;
    endtask

    task automatic wait_ready(output int n1, output int n0);
        n1 = 0;
        n0 = 0;
        for (int i = 1; i <= 60; i++) begin
            tick;
            if (n0 == 0 && ready0 === 1'b1) n0 = i;
            if (n1 == 0 && ready === 1'b1) n1 = i;
            if (n1 != 0 && n0 != 0) break;
        end
    endtask

    task automatic test_reset;
        int n1, n0;
        rst = 1'b1; idle; a_be = '0; a_addr = '0; b_addr = '0; a_wd = '0;
        tick; tick;
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
        total++; if ({a_rvalid, a_err, b_rvalid, b_err} !== 4'b0) begin bad++; $display("[TB] FAIL reset_flags: got %b want 0000", {a_rvalid, a_err, b_rvalid, b_err}); end
        total++; if (a_rd !== 32'h0 || b_rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_rd: got a=%h b=%h want 0", a_rd, b_rd); end
        rst = 1'b0;
        wait_ready(n1, n0);
        total++; if (n1 != 9) begin bad++; $display("[TB] FAIL ready_delay: got %0d edges want 9", n1); end
        total++; if (n0 != 1) begin bad++; $display("[TB] FAIL ready_noclear: got %0d edges want 1", n0); end
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
    endtask

    task automatic test_preload_clear;
        int n1, n0;
        do_write(16'd3, 32'hDEADBEEF, 4'hF);
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL write_rvalid: got %b want 0", a_rvalid); end
        do_read_a(16'd3);
        total++; if (a_rd !== 32'hDEADBEEF || a_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL preload_read: got %h/%b want deadbeef/1", a_rd, a_rvalid); end
        rst = 1'b1; tick; tick; rst = 1'b0;
        wait_ready(n1, n0);
        total++; if (n1 != 9) begin bad++; $display("[TB] FAIL reclear_delay: got %0d edges want 9", n1); end
        do_read_a(16'd3);
        total++; if (a_rd !== 32'h0 || a_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL cleared_read: got %h/%b want 0/1", a_rd, a_rvalid); end
    endtask

    task automatic test_byte_enable;
        do_write(16'd2, 32'h11223344, 4'b1111);
        do_write(16'd2, 32'hAABBCCDD, 4'b0101);
        do_read_a(16'd2);
        total++; if (a_rd !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL byte_merge: got %h want 11bb33dd", a_rd); end
        do_write(16'd2, 32'hFFFFFFFF, 4'b0000);
        do_read_a(16'd2);
        total++; if (a_rd !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL be_zero: got %h want 11bb33dd", a_rd); end
        model[2] = 32'h11BB33DD;
    endtask

    task automatic test_back_to_back;
        do_write(16'd4, 32'hA5A50F0F, 4'hF);
        do_read_a(16'd4);
        total++; if (a_rd !== 32'hA5A50F0F) begin bad++; $display("[TB] FAIL write_then_read: got %h want a5a50f0f", a_rd); end
        model[4] = 32'hA5A50F0F;
        a_req = 1'b1; a_we = 1'b0;
        a_addr = 16'd3; tick;
        total++; if (a_rd !== 32'h0 || a_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_0: got %h/%b want 0/1", a_rd, a_rvalid); end
        a_addr = 16'd4; tick;
        total++; if (a_rd !== 32'hA5A50F0F || a_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_1: got %h/%b want a5a50f0f/1", a_rd, a_rvalid); end
        a_addr = 16'd2; tick;
        total++; if (a_rd !== 32'h11BB33DD || a_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_2: got %h/%b want 11bb33dd/1", a_rd, a_rvalid); end
        idle; tick;
        total++; if (a_rvalid !== 1'b0 || a_rd !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL idle_hold: got %h/%b want 11bb33dd/0", a_rd, a_rvalid); end
    endtask

    task automatic test_forward;
        do_write(16'd5, 32'h12340000, 4'hF);
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'd5; a_wd = 32'h0000CAFE; a_be = 4'b0011;
        b_req = 1'b1; b_addr = 16'd5;
        tick; idle;
        total++; if (b_rd !== 32'h1234CAFE || b_rvalid !== 1'b1 || b_err !== 1'b0) begin bad++; $display("[TB] FAIL forward: got %h/%b/%b want 1234cafe/1/0", b_rd, b_rvalid, b_err); end
        model[5] = 32'h1234CAFE;
        do_read_a(16'd5);
        total++; if (a_rd !== 32'h1234CAFE) begin bad++; $display("[TB] FAIL forward_store: got %h want 1234cafe", a_rd); end
    endtask

    task automatic test_dual_read;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd4;
        b_req = 1'b1; b_addr = 16'd4;
        tick; idle;
        total++; if (a_rd !== 32'hA5A50F0F || b_rd !== 32'hA5A50F0F || !a_rvalid || !b_rvalid) begin bad++; $display("[TB] FAIL dual_read: got a=%h b=%h want a5a50f0f", a_rd, b_rd); end
    endtask

    task automatic test_out_of_range;
        do_write(16'd9, 32'hFFFFFFFF, 4'hF);
        total++; if (a_err !== 1'b1 || a_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL oor_write: got err=%b rvalid=%b want 1/0", a_err, a_rvalid); end
        tick;
        total++; if (a_err !== 1'b0) begin bad++; $display("[TB] FAIL oor_err_clear: got %b want 0", a_err); end
        for (int i = 0; i < 8; i++) begin
            do_read_a(16'(i));
            total++; if (a_rd !== model[i] || a_err !== 1'b0) begin bad++; $display("[TB] FAIL oor_intact_%0d: got %h err=%b want %h", i, a_rd, a_err, model[i]); end
        end
        b_req = 1'b1; b_addr = 16'd8;
        tick; idle;
        total++; if (b_rd !== 32'h0 || b_rvalid !== 1'b1 || b_err !== 1'b1) begin bad++; $display("[TB] FAIL oor_read_b: got %h/%b/%b want 0/1/1", b_rd, b_rvalid, b_err); end
    endtask

    task automatic test_gating_restart;
        int n1, n0;
        idle;
        rst = 1'b1; tick; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = 16'd2;
            b_req = 1'b1; b_addr = 16'd2;
            tick;
            total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL gated_%0d: got a=%b b=%b want 0", i, a_rvalid, b_rvalid); end
        end
        idle;
        rst = 1'b1; tick; rst = 1'b0;
        wait_ready(n1, n0);
        total++; if (n1 != 9) begin bad++; $display("[TB] FAIL restart_delay: got %0d edges want 9", n1); end
        do_read_a(16'd2);
        total++; if (a_rd !== 32'h0 || a_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL restart_clear: got %h/%b want 0/1", a_rd, a_rvalid); end
    endtask

    initial begin
        test_reset;
        test_preload_clear;
        test_byte_enable;
        test_back_to_back;
        test_forward;
        test_dual_read;
        test_out_of_range;
        test_gating_restart;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_dp.md
# dmem_dp

Parametrised dual-port data memory for the MIPS-E datapath. Port A is the CPU load/store port with byte enables, and port B is a read-only port for a sidecar/debug reader. Both ports have registered one-cycle reads and write-first forwarding. A built-in clear sequencer zeroes the array after reset before the block reports ready.

## Interface
Parameters:
- DATA_W, default 32 (`DATA_W`): word width; must be a multiple of 8.
- ADDR_W, default 16: word-address width.
- DEPTH, default 1024 (`DMEM_DEPTH`): words implemented; DEPTH ≤ 2^ADDR_W.
- INIT_CLEAR, default 1: 1 runs the zeroing sequence after reset; 0 skips it.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  the block accepts requests.
- a_req  in  1  port A request.
- a_we  in  1  port A write (1) or read (0).
- a_be  in  DATA_W/8  port A byte enables; bit i covers bits 8i+7:8i.
- a_addr  in  ADDR_W  port A word address.
- a_wd  in  DATA_W  port A write data.
- a_rd  out  DATA_W  port A read data.
- a_rvalid  out  1  a_rd is valid this cycle.
- a_err  out  1  port A address was out of range.
- b_req  in  1  port B read request.
- b_addr  in  ADDR_W  port B word address.
- b_rd  out  DATA_W  port B read data.
- b_rvalid  out  1  b_rd is valid this cycle.
- b_err  out  1  port B address was out of range.

## Operation
- FSM states: CLEAR, READY.
- rst=1 sets:
  - state ← CLEAR if INIT_CLEAR, else READY;
  - clr_cnt ← 0;
  - ready, a_rvalid, b_rvalid, a_err, b_err ← 0;
  - a_rd, b_rd ← 0.
- Memory contents are not reset.
- CLEAR:
  - each edge writes mem[clr_cnt] ← 0 and increments clr_cnt;
  - on the edge that writes DEPTH-1, state → READY.
- READY:
  - ready=1, held until the next rst.
  - ready is registered, so it is 0 in the first cycle after rst.
- Requests are accepted only when req & ready. Requests while ready=0 are dropped with no response.
- Port A read: on acceptance, a_rd ← mem[a_addr] and a_rvalid=1 for one cycle.
- Port A write:
  - mem[a_addr] bytes with a_be[i]=1 ← a_wd bytes; other bytes are unchanged.
  - a_rvalid stays 0.
  - a_be=0 leaves the word unchanged.
- Port B read: same as a port A read.
- Forwarding: if a port A write and a port B read hit the same address on the same edge, b_rd is the merged post-write word (write-first).
- Out of range (addr ≥ DEPTH):
  - writes are discarded;
  - reads return 0 with rvalid=1;
  - the port's err=1 for one cycle, alongside rvalid for reads and alone for writes.
- rvalid and err are cleared in any cycle with no accepted request. rd holds its last value.
- Both ports may read the same address on the same edge; both get the same data.

## Timing
- Read latency is 1 edge: a request accepted at edge N gives rd/rvalid during cycle N+1.
- Back-to-back reads run at one per cycle per port.
- Write latency is 1 edge: a read issued at edge N+1 returns the data written at edge N.
- Ready delay after rst falls:
  - INIT_CLEAR=1: ready first reads 1 after DEPTH+1 edges with rst=0 (DEPTH clear writes, then the registered ready).
  - INIT_CLEAR=0: ready first reads 1 after 1 edge.
- rst asserted mid-CLEAR restarts from clr_cnt=0.
- rst asserted in READY drops pending rvalid/err on that edge.

## Structure
- `DATA_W` and `DMEM_DEPTH` come from def.h and serve as the parameter defaults. Add `DMEM_ADDR_W` (16) to def.h.
- Sub-module dmem_clr_seq holds the CLEAR/READY FSM and clr_cnt, with outputs clr_we, clr_addr, ready.
- Top level holds:
  - the array;
  - the write mux (clear vs. port A);
  - byte merge;
  - per-port output registers;
  - range compare.

## Test plan
- Reset, clear and ready (DEPTH=8, INIT_CLEAR=1):
  - preload mem[3]=32'hDEADBEEF via backdoor, pulse rst for 2 cycles;
  - ready must rise after exactly 9 edges;
  - a port A read of 3 must return 0 one cycle later.
- Byte-enable write:
  - write addr 2, a_wd=32'h11223344, a_be=4'b1111;
  - then write addr 2, a_wd=32'hAABBCCDD, a_be=4'b0101;
  - a read of 2 must return 32'h11BB33DD.
- Same-edge forwarding:
  - port A writes 32'h0000CAFE to addr 5 (be=4'b0011; prior value 32'h12340000) while port B reads 5;
  - b_rd must be 32'h1234CAFE with b_rvalid=1.
- Out of range (DEPTH=8):
  - a port A write to 9 must leave every word unchanged and pulse a_err with a_rvalid=0;
  - a port B read of 8 must give b_rd=0, b_rvalid=1, b_err=1.
- Gating and restart:
  - issue reads while ready=0 → no rvalid;
  - assert rst at clr_cnt=4 → ready still waits the full 9 edges after rst falls;
  - INIT_CLEAR=0 → ready=1 after 1 edge.
